// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-PC generator with branch/JAL/JALR redirect, flush and misalignment handling
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   ex_valid, ex_is_branch,
//   ex_is_jal, ex_is_jalr      EX stage instruction class
//   branch_out                 comparator result for conditional branches
//   ex_pc, ex_imm, ex_rs1      operands for target computation
//   stall                      freezes sequential PC advance
//   if_ready                   fetch accepts pc this cycle
//   pc, pc_valid               registered fetch address and its validity
//   redirect, flush            redirect pulse and wrong-path squash
//   misalign_exc, misalign_addr  misaligned taken target pulse and captured address
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic        branch_out,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        stall,
    input  logic        if_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        redirect,
    output logic        flush,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr
);
    typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;
    localparam logic [2:0] FC1 = 3'(FLUSH_CYCLES - 1);
    state_t      state;
    logic [2:0]  count;
    logic [31:0] hold_tgt;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        take;
    logic        aligned;
    logic        run_take;
    always_comb begin
        target       = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : ex_pc + ex_imm;
        take         = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & branch_out));
        aligned      = target[1:0] == 2'b00;
        seq_pc       = (!stall && if_ready) ? pc + 32'd4 : pc;
        // EX takes are only honoured in RUN; HOLD and FLUSH see wrong-path or ignored EX
        run_take     = (state == RUN) & take & aligned;
        // gated by rst_n so all pulses read low while reset is held
        redirect     = rst_n & ((state == HOLD) ? if_ready : run_take & if_ready);
        flush        = rst_n & ((state != RUN) | run_take);
        misalign_exc = rst_n & (state == RUN) & take & ~aligned;
        pc_valid     = state != HOLD;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            state         <= RUN;
            count         <= 3'd0;
            hold_tgt      <= 32'd0;
            misalign_addr <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (run_take && if_ready) begin
                        pc    <= target;
                        count <= FC1;
                        state <= (FC1 == 3'd0) ? RUN : FLUSH;
                    end else if (run_take) begin
                        hold_tgt <= target;
                        state    <= HOLD;
                    end else begin
                        pc <= seq_pc;
                        if (misalign_exc) misalign_addr <= target;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        pc    <= hold_tgt;
                        count <= FC1;
                        state <= (FC1 == 3'd0) ? RUN : FLUSH;
                    end
                end
                FLUSH: begin
                    pc    <= seq_pc;
                    count <= count - 3'd1;
                    if (count <= 3'd1) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit against a behavioural model
module tb_pc_redirect_unit;
    localparam logic [31:0] RPC = 32'h100;
    localparam int FC = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0, branch_out = 1'b0;
    logic [31:0] ex_pc = 32'd0, ex_imm = 32'd0, ex_rs1 = 32'd0;
    logic        stall = 1'b0, if_ready = 1'b1;
    logic [31:0] pc, misalign_addr;
    logic        pc_valid, redirect, flush, misalign_exc;
    int total = 0;
    int bad = 0;
    logic [31:0] p;

    pc_redirect_unit #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .branch_out(branch_out),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .stall(stall), .if_ready(if_ready),
        .pc(pc), .pc_valid(pc_valid), .redirect(redirect), .flush(flush),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; branch_out = 0;
    endtask

    task automatic set_ex(input logic br, input logic jal, input logic jalr, input logic bo,
                          input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] rs1);
        ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr; branch_out = bo;
        ex_pc = epc; ex_imm = imm; ex_rs1 = rs1;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        rst_n = 1;
        repeat (3) cyc();
        #2;
        set_ex(0, 1, 0, 0, 32'h40, 32'h2, 0);
        rst_n = 0;
        #1;
        total++; if (pc !== RPC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, RPC); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
        total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b exp=0", misalign_exc); end
        total++; if (misalign_addr !== 32'd0) begin bad++; $display("FAIL reset_maddr got=%h exp=0", misalign_addr); end
        total++; if (pc_valid !== 1'b1) begin bad++; $display("FAIL reset_pc_valid got=%b exp=1", pc_valid); end
        idle();
        cyc();
        rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            total++; if (pc !== RPC + 32'(4 * i)) begin bad++; $display("FAIL reset_seq%0d got=%h exp=%h", i, pc, RPC + 32'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        set_ex(1, 0, 0, 1, 32'h200, 32'hFFFF_FFF0, 0);
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL br_redirect got=%b exp=1", redirect); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL br_flush0 got=%b exp=1", flush); end
        cyc(); idle();
        total++; if (pc !== 32'h1F0) begin bad++; $display("FAIL br_target got=%h exp=1f0", pc); end
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL br_flush1 got=%b exp=1", flush); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL br_redirect1 got=%b exp=0", redirect); end
        cyc(); #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL br_flush2 got=%b exp=0", flush); end
        total++; if (pc !== 32'h1F4) begin bad++; $display("FAIL br_seq got=%h exp=1f4", pc); end
        p = pc;
        set_ex(1, 0, 0, 0, 32'h200, 32'hFFFF_FFF0, 0);
        #1;
        total++; if (flush !== 1'b0 || redirect !== 1'b0) begin bad++; $display("FAIL br_nt flush=%b redirect=%b exp=0,0", flush, redirect); end
        cyc(); idle();
        total++; if (pc !== p + 32'd4) begin bad++; $display("FAIL br_nt_pc got=%h exp=%h", pc, p + 32'd4); end
    endtask

    task automatic test_jalr();
        set_ex(0, 1, 1, 0, 32'h500, 32'h4, 32'h1001);
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL jalr_redirect got=%b exp=1", redirect); end
        cyc(); idle();
        total++; if (pc !== 32'h1004) begin bad++; $display("FAIL jalr_target got=%h exp=1004", pc); end
        cyc();
    endtask

    task automatic test_backpressure();
        p = pc;
        if_ready = 0;
        set_ex(0, 1, 0, 0, 32'h300, 32'h100, 0);
        #1;
        total++; if (flush !== 1'b1 || redirect !== 1'b0) begin bad++; $display("FAIL bp_take flush=%b redirect=%b exp=1,0", flush, redirect); end
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); #1;
            total++; if (pc !== p) begin bad++; $display("FAIL bp_pc%0d got=%h exp=%h", i, pc, p); end
            total++; if (pc_valid !== 1'b0 || flush !== 1'b1 || redirect !== 1'b0) begin bad++; $display("FAIL bp_hold%0d valid=%b flush=%b redirect=%b exp=0,1,0", i, pc_valid, flush, redirect); end
        end
        if_ready = 1;
        #1;
        total++; if (redirect !== 1'b1 || flush !== 1'b1) begin bad++; $display("FAIL bp_release redirect=%b flush=%b exp=1,1", redirect, flush); end
        cyc();
        total++; if (pc !== 32'h400) begin bad++; $display("FAIL bp_target got=%h exp=400", pc); end
        #1;
        total++; if (redirect !== 1'b0 || flush !== 1'b1 || pc_valid !== 1'b1) begin bad++; $display("FAIL bp_flush redirect=%b flush=%b valid=%b exp=0,1,1", redirect, flush, pc_valid); end
        cyc(); #1;
        total++; if (flush !== 1'b0 || pc !== 32'h404) begin bad++; $display("FAIL bp_done flush=%b pc=%h exp=0,404", flush, pc); end
    endtask

    task automatic test_misalign();
        p = pc;
        set_ex(0, 1, 0, 0, 32'h40, 32'h2, 0);
        #1;
        total++; if (misalign_exc !== 1'b1 || flush !== 1'b0 || redirect !== 1'b0) begin bad++; $display("FAIL mis_take exc=%b flush=%b redirect=%b exp=1,0,0", misalign_exc, flush, redirect); end
        cyc(); idle();
        total++; if (pc !== p + 32'd4) begin bad++; $display("FAIL mis_pc got=%h exp=%h", pc, p + 32'd4); end
        total++; if (misalign_addr !== 32'h42) begin bad++; $display("FAIL mis_addr got=%h exp=42", misalign_addr); end
        #1;
        total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", misalign_exc); end
        set_ex(0, 1, 0, 0, 32'h600, 32'h0, 0);
        cyc();
        set_ex(0, 1, 0, 0, 32'h700, 32'h0, 0);
        #1;
        total++; if (redirect !== 1'b0 || flush !== 1'b1) begin bad++; $display("FAIL wrongpath redirect=%b flush=%b exp=0,1", redirect, flush); end
        cyc(); idle();
        total++; if (pc !== 32'h604) begin bad++; $display("FAIL wrongpath_pc got=%h exp=604", pc); end
    endtask

    task automatic test_stall_wrap();
        stall = 1;
        p = pc;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (pc !== p) begin bad++; $display("FAIL stall%0d got=%h exp=%h", i, pc, p); end
        end
        set_ex(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 0);
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL stall_redirect got=%b exp=1", redirect); end
        cyc(); idle();
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL stall_target got=%h exp=fffffffc", pc); end
        stall = 0;
        cyc();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap got=%h exp=0", pc); end
        cyc();
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_htgt, m_maddr, tgt;
        logic        m_hold, tk, mis, e_redir, e_flush, e_exc, e_valid;
        int          m_fl;
        rst_n = 0; #1; rst_n = 1;
        m_pc = RPC; m_htgt = 0; m_maddr = 0; m_hold = 0; m_fl = 0;
        for (int n = 0; n < 3000; n++) begin
            ex_valid = ($urandom % 4) != 0;
            ex_is_branch = $urandom % 2; ex_is_jal = ($urandom % 4) == 0; ex_is_jalr = ($urandom % 4) == 0;
            branch_out = $urandom % 2;
            ex_pc = $urandom & 32'hFFFF_FFFC;
            ex_imm = ($urandom & 32'hFFFF_FFFC) | ((($urandom % 4) == 0) ? 32'h2 : 32'h0);
            ex_rs1 = $urandom;
            if_ready = ($urandom % 4) != 0;
            stall = ($urandom % 4) == 0;
            #1;
            tgt = ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : ex_pc + ex_imm;
            tk = ex_valid && (ex_is_jalr || ex_is_jal || (ex_is_branch && branch_out));
            mis = tgt[1:0] != 2'b00;
            if (m_hold) begin
                e_redir = if_ready; e_flush = 1; e_exc = 0; e_valid = 0;
            end else if (m_fl > 0) begin
                e_redir = 0; e_flush = 1; e_exc = 0; e_valid = 1;
            end else begin
                e_redir = tk && !mis && if_ready; e_flush = tk && !mis; e_exc = tk && mis; e_valid = 1;
            end
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
            total++; if (redirect !== e_redir || flush !== e_flush) begin bad++; $display("FAIL rnd_ctl n=%0d redirect=%b flush=%b exp=%b,%b", n, redirect, flush, e_redir, e_flush); end
            total++; if (misalign_exc !== e_exc || pc_valid !== e_valid) begin bad++; $display("FAIL rnd_exc n=%0d exc=%b valid=%b exp=%b,%b", n, misalign_exc, pc_valid, e_exc, e_valid); end
            total++; if (misalign_addr !== m_maddr) begin bad++; $display("FAIL rnd_maddr n=%0d got=%h exp=%h", n, misalign_addr, m_maddr); end
            if (m_hold) begin
                if (if_ready) begin m_pc = m_htgt; m_hold = 0; m_fl = FC - 1; end
            end else if (m_fl > 0) begin
                if (!stall && if_ready) m_pc = m_pc + 4;
                m_fl--;
            end else if (tk && !mis) begin
                if (if_ready) begin m_pc = tgt; m_fl = FC - 1; end
                else begin m_hold = 1; m_htgt = tgt; end
            end else begin
                if (!stall && if_ready) m_pc = m_pc + 4;
                if (tk) m_maddr = tgt;
            end
            cyc();
        end
        idle(); stall = 0; if_ready = 1;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr();
        test_backpressure();
        test_misalign();
        test_stall_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-PC generator and control-flow redirect stage for the RV32 core. Sits directly downstream of the branch comparator. Consumes its taken/not-taken result together with JAL/JALR decode from EX, computes the target address, and drives the fetch PC. Generates the pipeline flush and redirect handshakes that squash wrong-path instructions in IF/ID and ID/EX.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- FLUSH_CYCLES, 2, cycles `flush` stays high per redirect, counted from the redirect cycle; legal range 1..7

Ports:
- clk  in  1  single core clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- ex_valid  in  1  EX holds a valid instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_is_jal  in  1  EX instruction is JAL
- ex_is_jalr  in  1  EX instruction is JALR
- branch_out  in  1  comparator result, 1 = condition true
- ex_pc  in  32  PC of the EX instruction
- ex_imm  in  32  sign-extended immediate
- ex_rs1  in  32  rs1 operand, used for JALR
- stall  in  1  hazard stall; freezes sequential PC advance
- if_ready  in  1  fetch accepts `pc` this cycle
- pc  out  32  current fetch address, registered
- pc_valid  out  1  `pc` is a legal fetch request
- redirect  out  1  one-cycle pulse when `pc` loads a target
- flush  out  1  kill IF/ID and ID/EX contents
- misalign_exc  out  1  one-cycle pulse on a misaligned taken target
- misalign_addr  out  32  captured misaligned target, holds until the next exception

## Operation
- **Target selection:** jalr has priority over jal, and jal over branch.
  - JALR target = (ex_rs1 + ex_imm) & ~32'h1.
  - JAL and branch target = ex_pc + ex_imm.
  - All sums are modulo 2^32; carry is dropped.
- **take** = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & branch_out)).
- **Alignment:** aligned = (target[1:0] == 0) after the JALR bit-0 clear. A take with target[1] = 1 causes:
  - no redirect and no flush;
  - misalign_exc = 1 for that cycle;
  - misalign_addr <= target at the next edge;
  - PC continues its sequential advance.
- **State machine:** states RUN, HOLD, FLUSH.
- **RUN:**
  - Aligned take and if_ready = 1: pc <= target, redirect = 1, flush = 1. Go to FLUSH with count = FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES = 1.
  - Aligned take and if_ready = 0: latch target into hold_tgt, flush = 1, go to HOLD.
  - No take: if !stall & if_ready then pc <= pc + 4, otherwise pc holds.
- **HOLD:**
  - flush = 1, pc_valid = 0; all EX inputs are ignored.
  - When if_ready = 1: pc <= hold_tgt, redirect = 1, go to FLUSH with count = FLUSH_CYCLES-1 (RUN if that count is 0).
- **FLUSH:**
  - flush = 1 and pc_valid = 1; EX take is ignored (wrong path).
  - PC advances sequentially under the RUN rule.
  - count decrements each cycle; go to RUN when count reaches 0.
- **Stall vs redirect:** a redirect overrides stall, because stall applies to younger instructions only.
- **PC wrap:** 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
- **Output decode:**
  - redirect and flush are combinational from state and EX inputs.
  - pc_valid = (state != HOLD).

## Timing
- Reset (rst_n = 0, asynchronous) forces immediately:
  - pc = RESET_PC, state = RUN, count = 0, hold_tgt = 0;
  - misalign_addr = 0, redirect = 0, flush = 0, misalign_exc = 0.
- The first clock edge after deassertion may advance pc.
- Reset asserted in HOLD or FLUSH abandons the pending target; there are no leftover flush cycles.
- Redirect latency:
  - target visible on `pc` one edge after the take cycle when if_ready = 1;
  - with backpressure, one edge after the first cycle if_ready = 1.
- flush duration:
  - high in the take cycle, then FLUSH_CYCLES-1 further cycles (FLUSH_CYCLES cycles total, if_ready = 1);
  - in HOLD, flush is additionally high for every cycle spent waiting.
- misalign_exc is combinational and occurs in the same cycle as the take. misalign_addr updates at the following edge.
- A take and stall in the same cycle: the redirect happens and stall is ignored.

## Test plan
- **Reset:** rst_n low mid-run with RESET_PC = 32'h100 → pc = 32'h100 without a clock edge; after release, three cycles with if_ready = 1 and stall = 0 → pc = 104, 108, 10C.
- **Taken branch:** ex_pc = 32'h200, ex_imm = 32'hFFFF_FFF0, branch_out = 1, if_ready = 1 → redirect pulse, next pc = 32'h1F0, flush high for 2 cycles (default parameters). With branch_out = 0 → no flush, pc += 4.
- **JALR:** ex_rs1 = 32'h1001, ex_imm = 4, with ex_is_jal = 1 also asserted → JALR wins, target = 32'h1004.
- **Backpressure:** JAL take with if_ready low for 3 cycles → state HOLD, pc_valid = 0, flush high for 3 cycles, pc unchanged. Then if_ready = 1 → pc = target, redirect for 1 cycle, then 1 more flush cycle.
- **Misaligned target:** ex_pc = 32'h40, ex_imm = 2, taken → misalign_exc for 1 cycle, misalign_addr = 32'h42, no flush, pc += 4. A wrong-path take during FLUSH is ignored.
- **Stall and wrap:** stall = 1 for 4 cycles → pc frozen; stall with a simultaneous JAL → redirect happens anyway. pc = 32'hFFFF_FFFC with an advance → pc = 0.
